// File: rtl/cmd_line_parser.sv
// Command-line parser: fetches an ASCII command from memory and decodes a map number plus
// optional name, or a rank/version request; next/prev step the decoded map index while idle.
module cmd_line_parser #(
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned BASE_ADDR  = 120,
    parameter int unsigned MAX_LEN    = 32,
    parameter int unsigned NAME_CHARS = 8,
    parameter int unsigned MAX_INDEX  = 80,
    parameter int unsigned IDX_W      = 7,
    parameter int unsigned READ_LAT   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    next,
    input  logic                    prev,
    output logic                    rea,
    output logic [ADDR_W-1:0]       VAddr,
    input  logic [7:0]              VData,
    output logic [IDX_W-1:0]        index,
    output logic [8*NAME_CHARS-1:0] name,
    output logic                    is_index,
    output logic                    is_rank,
    output logic                    is_version,
    output logic                    is_error,
    output logic                    busy,
    output logic                    done,
    output logic                    load_next,
    output logic                    load_prev
);
    localparam int unsigned ACC_W  = IDX_W + 4;
    localparam int unsigned MUL_W  = ACC_W + 4;
    localparam int unsigned LAT_W  = $clog2(READ_LAT + 1);
    localparam int unsigned CNT_W  = $clog2(MAX_LEN + 1);
    localparam int unsigned NPOS_W = $clog2(NAME_CHARS + 1);
    localparam int unsigned NAME_W = 8 * NAME_CHARS;

    // "unknown" padded with NULs, or truncated when the name field is shorter.
    function automatic logic [NAME_W-1:0] default_name();
        logic [NAME_W-1:0] r;
        logic [55:0]       u;
        r = '0;
        u = "unknown";
        for (int unsigned k = 0; k < NAME_CHARS; k++) begin
            if (k < 7) begin
                r[8*(NAME_CHARS-1-k) +: 8] = u[55 -: 8];
                u = {u[47:0], 8'h00};
            end
        end
        return r;
    endfunction

    localparam logic [NAME_W-1:0] DEF_NAME = default_name();

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_PARSE} state_t;
    typedef enum logic [1:0] {M_FIRST, M_DIGIT, M_NAME} mode_t;

    state_t              state_q, state_d;
    mode_t               mode_q, mode_d;
    logic [LAT_W-1:0]    wcnt_q, wcnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NPOS_W-1:0]   npos_q, npos_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [7:0]          char_q, char_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic [NAME_W-1:0]   name_q, name_d;
    logic                is_index_q, is_index_d, is_rank_q, is_rank_d;
    logic                is_version_q, is_version_d, is_error_q, is_error_d;
    logic                load_next_q, load_next_d, load_prev_q, load_prev_d;
    logic                rea_q, rea_d, busy_q, busy_d, done_q, done_d;
    logic                end_c, fin_c, is_dig_c;
    logic [MUL_W-1:0]    acc_mul;

    assign is_dig_c = (char_q >= 8'h30) && (char_q <= 8'h39);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        wcnt_d       = wcnt_q;
        cnt_d        = cnt_q;
        npos_d       = npos_q;
        acc_d        = acc_q;
        char_d       = char_q;
        addr_d       = addr_q;
        index_d      = index_q;
        name_d       = name_q;
        is_index_d   = is_index_q;
        is_rank_d    = is_rank_q;
        is_version_d = is_version_q;
        is_error_d   = is_error_q;
        load_next_d  = 1'b0;
        load_prev_d  = 1'b0;
        end_c        = 1'b0;
        fin_c        = 1'b0;
        acc_mul      = MUL_W'(acc_q) * MUL_W'(10) + MUL_W'(char_q - 8'h30);

        case (state_q)
            S_IDLE: begin
                if (!start && (next != prev)) begin
                    if (next && (index_q < IDX_W'(MAX_INDEX - 1))) begin
                        index_d     = index_q + IDX_W'(1);
                        load_next_d = 1'b1;
                    end else if (prev && (index_q != '0)) begin
                        index_d     = index_q - IDX_W'(1);
                        load_prev_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q == LAT_W'(READ_LAT - 1)) state_d = S_CAPTURE;
                else                                 wcnt_d  = wcnt_q + LAT_W'(1);
            end
            S_CAPTURE: begin
                char_d  = VData;
                state_d = S_PARSE;
            end
            S_PARSE: begin
                case (mode_q)
                    M_FIRST: begin
                        if (is_dig_c) begin
                            mode_d = M_DIGIT;
                            acc_d  = ACC_W'(char_q - 8'h30);
                        end else if (char_q == 8'h72) begin
                            is_rank_d = 1'b1;
                            end_c     = 1'b1;
                        end else if (char_q == 8'h76) begin
                            is_version_d = 1'b1;
                            end_c        = 1'b1;
                        end else begin
                            is_error_d = 1'b1;
                            end_c      = 1'b1;
                        end
                    end
                    M_DIGIT: begin
                        if (is_dig_c) begin
                            if (acc_mul > MUL_W'(MAX_INDEX + 1)) acc_d = ACC_W'(MAX_INDEX + 1);
                            else                                 acc_d = ACC_W'(acc_mul);
                        end else if (char_q == 8'h20) begin
                            mode_d = M_NAME;
                            name_d = '0;
                            npos_d = '0;
                        end else if (char_q == 8'h00) begin
                            fin_c = 1'b1;
                        end else begin
                            is_error_d = 1'b1;
                            end_c      = 1'b1;
                        end
                    end
                    M_NAME: begin
                        if ((char_q == 8'h00) || (char_q == 8'h20)) begin
                            fin_c = 1'b1;
                        end else begin
                            for (int unsigned b = 0; b < NAME_CHARS; b++) begin
                                if (NPOS_W'(b) == npos_q) name_d[8*(NAME_CHARS-1-b) +: 8] = char_q;
                            end
                            npos_d = npos_q + NPOS_W'(1);
                            if (npos_q == NPOS_W'(NAME_CHARS - 1)) fin_c = 1'b1;
                        end
                    end
                    default: end_c = 1'b1;
                endcase

                // Running out of scan budget is an error, but a partial number/name still finalises.
                cnt_d = cnt_q + CNT_W'(1);
                if (!end_c && !fin_c && (cnt_d == CNT_W'(MAX_LEN))) begin
                    is_error_d = 1'b1;
                    if (mode_d != M_FIRST) fin_c = 1'b1;
                    else                   end_c = 1'b1;
                end

                if (fin_c) begin
                    is_index_d = 1'b1;
                    if ((acc_d != '0) && (acc_d <= ACC_W'(MAX_INDEX))) begin
                        index_d = IDX_W'(acc_d - ACC_W'(1));
                    end else begin
                        index_d    = '0;
                        is_error_d = 1'b1;
                    end
                end

                if (fin_c || end_c) begin
                    state_d = S_IDLE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // start from any state (re)initialises the parse.
        if (start) begin
            state_d      = S_ISSUE;
            mode_d       = M_FIRST;
            wcnt_d       = '0;
            cnt_d        = '0;
            npos_d       = '0;
            acc_d        = '0;
            addr_d       = ADDR_W'(BASE_ADDR);
            index_d      = '0;
            name_d       = DEF_NAME;
            is_index_d   = 1'b0;
            is_rank_d    = 1'b0;
            is_version_d = 1'b0;
            is_error_d   = 1'b0;
        end

        rea_d  = (state_d == S_ISSUE) || (state_d == S_WAIT);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_q       <= M_FIRST;
            wcnt_q       <= '0;
            cnt_q        <= '0;
            npos_q       <= '0;
            acc_q        <= '0;
            char_q       <= '0;
            addr_q       <= ADDR_W'(BASE_ADDR);
            index_q      <= '0;
            name_q       <= DEF_NAME;
            is_index_q   <= 1'b0;
            is_rank_q    <= 1'b0;
            is_version_q <= 1'b0;
            is_error_q   <= 1'b0;
            load_next_q  <= 1'b0;
            load_prev_q  <= 1'b0;
            rea_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            wcnt_q       <= wcnt_d;
            cnt_q        <= cnt_d;
            npos_q       <= npos_d;
            acc_q        <= acc_d;
            char_q       <= char_d;
            addr_q       <= addr_d;
            index_q      <= index_d;
            name_q       <= name_d;
            is_index_q   <= is_index_d;
            is_rank_q    <= is_rank_d;
            is_version_q <= is_version_d;
            is_error_q   <= is_error_d;
            load_next_q  <= load_next_d;
            load_prev_q  <= load_prev_d;
            rea_q        <= rea_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign rea        = rea_q;
    assign VAddr      = addr_q;
    assign index      = index_q;
    assign name       = name_q;
    assign is_index   = is_index_q;
    assign is_rank    = is_rank_q;
    assign is_version = is_version_q;
    assign is_error   = is_error_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_next  = load_next_q;
    assign load_prev  = load_prev_q;
endmodule

// File: tb/tb_cmd_line_parser.sv
// Bench for cmd_line_parser: pipelined memory model, software parse model, per-cycle compare.
module tb_cmd_line_parser;
    localparam int RL     = 2;
    localparam int BASE   = 120;
    localparam int MAXI   = 80;
    localparam int MAXLEN = 32;
    localparam int NC     = 8;
    localparam logic [63:0] DEF_NAME = {"unknown", 8'h00};

    logic        clk = 1'b0;
    logic        rst, start, next, prev;
    logic        rea, is_index, is_rank, is_version, is_error, busy, done, load_next, load_prev;
    logic [10:0] VAddr;
    logic [7:0]  VData;
    logic [6:0]  index;
    logic [63:0] name;

    logic [7:0]  mem [0:2047];
    logic [7:0]  p0, p1;

    int          checks = 0;
    int          errors = 0;
    bit          model_valid = 0;
    int          m_idx, m_reads;
    logic [63:0] m_name;
    bit          m_isidx, m_rank, m_ver, m_err, m_ln, m_lp;
    logic [10:0] rd_q [$];
    bit          rea_last = 0;
    logic [10:0] addr_last = '0;
    int          last_cyc, rd_base, pulses;

    cmd_line_parser dut (
        .clk(clk), .rst(rst), .start(start), .next(next), .prev(prev),
        .rea(rea), .VAddr(VAddr), .VData(VData), .index(index), .name(name),
        .is_index(is_index), .is_rank(is_rank), .is_version(is_version), .is_error(is_error),
        .busy(busy), .done(done), .load_next(load_next), .load_prev(load_prev)
    );

    always #5 clk = ~clk;

    // Memory returns data RL clocks after the address is presented.
    always @(posedge clk) begin
        p0 <= mem[VAddr];
        p1 <= p0;
    end
    assign VData = p1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // One cycle: advance to the negedge, log new reads, compare idle outputs to the model.
    task automatic tick();
        @(negedge clk);
        if (rea && (!rea_last || VAddr != addr_last)) rd_q.push_back(VAddr);
        rea_last  = rea;
        addr_last = VAddr;
        chk("busy_xor_done", busy ^ done, 1);
        if (model_valid) begin
            chk("index", index, m_idx);
            chk("name", name, m_name);
            chk("flags", {is_index, is_rank, is_version, is_error}, {m_isidx, m_rank, m_ver, m_err});
            chk("idle_status", {busy, done, rea}, 3'b010);
            chk("pulses", {load_next, load_prev}, {m_ln, m_lp});
        end
    endtask

    function automatic bit isdig(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    // Software parse of the command stored at BASE.
    task automatic model_parse();
        int acc, n, k;
        logic [7:0] c;
        bit fin, stop, to_name;
        m_idx = 0; m_name = DEF_NAME; m_isidx = 0; m_rank = 0; m_ver = 0; m_err = 0;
        m_ln = 0; m_lp = 0;
        acc = 0; fin = 0; to_name = 0; n = 1; c = mem[BASE];
        if (c == 8'h72) m_rank = 1;
        else if (c == 8'h76) m_ver = 1;
        else if (!isdig(c)) m_err = 1;
        else begin
            acc = int'(c) - 48; stop = 0;
            while (!stop) begin
                if (n == MAXLEN) begin m_err = 1; fin = 1; stop = 1; end
                else begin
                    c = mem[BASE+n]; n++;
                    if (isdig(c)) begin
                        acc = acc * 10 + int'(c) - 48;
                        if (acc > MAXI + 1) acc = MAXI + 1;
                    end
                    else if (c == 8'h00) begin fin = 1; stop = 1; end
                    else if (c == 8'h20) begin to_name = 1; stop = 1; end
                    else begin m_err = 1; stop = 1; end
                end
            end
            if (to_name) begin
                m_name = '0; k = 0; stop = 0;
                while (!stop) begin
                    if (n == MAXLEN) begin m_err = 1; fin = 1; stop = 1; end
                    else begin
                        c = mem[BASE+n]; n++;
                        if (c == 8'h00 || c == 8'h20) begin fin = 1; stop = 1; end
                        else begin
                            m_name[8*(NC-1-k) +: 8] = c; k++;
                            if (k == NC) begin fin = 1; stop = 1; end
                        end
                    end
                end
            end
        end
        if (fin) begin
            m_isidx = 1;
            if (acc >= 1 && acc <= MAXI) m_idx = acc - 1;
            else m_err = 1;
        end
        m_reads = n;
    endtask

    task automatic load_mem(input string s);
        for (int i = 0; i < 300; i++) mem[BASE+i] = 8'h00;
        for (int i = 0; i < s.len(); i++) mem[BASE+i] = s[i];
    endtask

    task automatic do_reset();
        model_valid = 0;
        rst = 1; start = 1;
        tick();
        chk("rst_status", {busy, done, rea}, 3'b010);
        chk("rst_vaddr", VAddr, BASE);
        chk("rst_index", index, 0);
        chk("rst_name", name, DEF_NAME);
        chk("rst_flags", {is_index, is_rank, is_version, is_error, load_next, load_prev}, 6'b0);
        rst = 0; start = 0;
        m_idx = 0; m_name = DEF_NAME; m_isidx = 0; m_rank = 0; m_ver = 0; m_err = 0;
        m_ln = 0; m_lp = 0;
        model_valid = 1;
    endtask

    task automatic run_parse();
        int  ncyc;
        bit  got;
        tick();
        model_valid = 0; rd_base = rd_q.size(); start = 1; ncyc = 0; got = 0;
        while (ncyc < 400 && !got) begin
            tick(); ncyc++; start = 0;
            if (done) got = 1;
        end
        chk("done_seen", got, 1);
        model_parse();
        last_cyc = ncyc;
        chk("latency", ncyc, m_reads * (RL + 3) + 1);
        chk("nreads", rd_q.size() - rd_base, m_reads);
        for (int i = rd_base; i < rd_q.size(); i++)
            if (i - rd_base < m_reads) chk("raddr", rd_q[i], BASE + i - rd_base);
        model_valid = 1;
    endtask

    task automatic kick(input int cyc);
        model_valid = 0; start = 1;
        tick();
        start = 0;
        repeat (cyc - 1) tick();
    endtask

    task automatic step(input bit n, input bit p);
        int ni;
        next = n; prev = p; ni = m_idx; pulses = 0;
        if (n && !p && m_idx < MAXI - 1) begin ni = m_idx + 1; m_ln = 1; end
        else if (p && !n && m_idx > 0) begin ni = m_idx - 1; m_lp = 1; end
        m_idx = ni;
        tick();
        pulses += int'(load_next) + int'(load_prev);
        next = 0; prev = 0; m_ln = 0; m_lp = 0;
        tick();
        pulses += int'(load_next) + int'(load_prev);
    endtask

    initial begin
        string s;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        rst = 0; start = 0; next = 0; prev = 0;
        do_reset();

        load_mem("12 alice"); run_parse();
        chk("alice_index", index, 11);
        chk("alice_name", name, {"alice", 24'h0});
        chk("alice_flags", {is_index, is_error}, 2'b10);
        chk("alice_last", rd_q[rd_q.size()-1], 128);

        load_mem("r"); run_parse();
        chk("rank_flag", is_rank, 1);
        chk("rank_latency", last_cyc, RL + 4);
        chk("rank_index", index, 0);

        load_mem("v"); run_parse();
        load_mem("95"); run_parse();
        chk("95_flags", {index, is_index, is_error}, {7'd0, 2'b11});
        load_mem("0"); run_parse();
        chk("0_flags", {index, is_index, is_error}, {7'd0, 2'b11});

        load_mem("7 abcdefghij"); run_parse();
        chk("trunc_name", name, "abcdefgh");
        chk("trunc_index", index, 6);
        chk("trunc_last", rd_q[rd_q.size()-1], 129);

        load_mem("1x"); run_parse();
        load_mem(" 5"); run_parse();
        load_mem("80 z"); run_parse();
        chk("max_index", index, 79);
        s = "";
        for (int i = 0; i < MAXLEN; i++) s = {s, "1"};
        load_mem(s); run_parse();
        chk("maxlen_flags", {is_index, is_error}, 2'b11);

        load_mem("12 alice"); kick(12); run_parse();
        chk("abort_index", index, 11);

        load_mem("79"); run_parse();
        step(1, 0); chk("next_index", index, 79); chk("next_pulse", pulses, 1);
        step(1, 0); chk("next_sat", index, 79); chk("next_sat_pulse", pulses, 0);
        step(0, 1); chk("prev_index", index, 78);
        step(1, 1); chk("both_index", index, 78);
        load_mem("1"); run_parse();
        step(0, 1); chk("prev_zero", index, 0); chk("prev_zero_pulse", pulses, 0);

        load_mem("12 alice"); kick(15); do_reset();
        load_mem("5 bob"); run_parse();
        chk("fresh_name", name, {"bob", 40'h0});
        chk("fresh_index", index, 4);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmd_line_parser.md
CMD_LINE_PARSER -- requirements
Module: cmd_line_parser

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning command-memory address width.
REQ-002 SHALL have parameter BASE_ADDR, default 120, meaning address of first command character.
REQ-003 SHALL have parameter MAX_LEN, default 32, meaning maximum characters scanned per command.
REQ-004 SHALL have parameter NAME_CHARS, default 8, meaning name field length in bytes.
REQ-005 SHALL have parameter MAX_INDEX, default 80, meaning highest legal 1-based map number.
REQ-006 SHALL have parameter IDX_W, default 7, meaning index width; ceil(log2(MAX_INDEX+1)) or more.
REQ-007 SHALL have parameter READ_LAT, default 2, meaning memory cycles from address to valid data (>=1).
REQ-008 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous and active-high, on one clock.
REQ-009 SHALL have ports: start in 1 begin parse; next in 1 step index up; prev in 1 step index down.
REQ-010 SHALL have ports: rea out 1 memory read enable; VAddr out ADDR_W address; VData in 8 character.
REQ-011 SHALL have ports: index out IDX_W 0-based map index; name out 8*NAME_CHARS ASCII, first char in MSB byte.
REQ-012 SHALL have ports: is_index, is_rank, is_version, is_error out 1 result flags; busy out 1; done out 1.
REQ-013 SHALL have ports: load_next, load_prev out 1, one-cycle pulses.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> WAIT -> CAPTURE -> PARSE -> (ISSUE | IDLE).
REQ-015 IDLE: busy=0, done=1, rea=0; start -> clear all flags, index=0, name=default, char count=0, addr=BASE_ADDR, go ISSUE.
REQ-016 ISSUE: rea=1, VAddr=current address; WAIT holds rea=1 and VAddr for READ_LAT cycles; CAPTURE latches VData; each character costs READ_LAT+3 cycles.
REQ-017 PARSE, token 0 first char: digit -> digit mode; 'r' (0x72) -> is_rank=1, end; 'v' (0x76) -> is_version=1, end; anything else incl. NUL -> is_error=1, end.
REQ-018 Digit mode: acc = acc*10 + (char-0x30), saturating at MAX_INDEX+1 in a register of IDX_W+4 bits; non-digit other than space/NUL -> is_error=1, end.
REQ-019 Space (0x20) in token 0 -> name mode, name cleared to all 0x00; NUL in digit mode -> finalise.
REQ-020 Name mode: k-th char (k=0..NAME_CHARS-1) written to byte k from MSB; NUL or space -> finalise; after NAME_CHARS chars -> finalise without further reads.
REQ-021 Finalise: acc in 1..MAX_INDEX -> index=acc-1, is_index=1; acc=0 or >MAX_INDEX -> index=0, is_index=1, is_error=1.
REQ-022 Char count reaching MAX_LEN without end -> is_error=1, finalise if digit/name mode, return IDLE.
REQ-023 Any end -> rea=0 and state IDLE next cycle; done rises with busy falling in same cycle.
REQ-024 start while busy SHALL abort and restart from REQ-015 next cycle.
REQ-025 next/prev SHALL be honoured only in IDLE with start low; next and prev together -> ignored.
REQ-026 next with index < MAX_INDEX-1 -> index+1, load_next=1 one cycle; at MAX_INDEX-1 -> no change, no pulse.
REQ-027 prev with index > 0 -> index-1, load_prev=1 one cycle; at 0 -> no change, no pulse.
REQ-028 Default name SHALL be "unknown" followed by 0x00 bytes, truncated to NAME_CHARS if shorter.

Reset
REQ-029 rst SHALL force IDLE, rea=0, VAddr=BASE_ADDR, index=0, name=default, all flags 0, load_next=load_prev=0, busy=0, done=1.
REQ-030 rst asserted mid-parse SHALL override start and discard partial results.

Verification
REQ-031 Memory "12 alice\0" at 120, start -> index=11, name="alice" + 3 NULs, is_index=1, is_error=0, reads at 120..128.
REQ-032 Memory "r..." -> is_rank=1, index=0, one character read, done after READ_LAT+4 cycles from start.
REQ-033 Memory "95\0" and "0\0" -> index=0, is_index=1, is_error=1.
REQ-034 Memory "7 abcdefghij" -> name="abcdefgh", index=6, reads stop at address 129.
REQ-035 index=78, next x2 -> index=79 with one load_next pulse, then no change; prev at 0 -> no pulse.
REQ-036 rst at PARSE of third char then start -> fresh parse from 120, no stale name bytes.
